mil1553_tx_encoder: RTL and testbench

MIL1553_TX_ENCODER -- requirements
Module: mil1553_tx_encoder

---
 rtl/mil1553_tx_encoder_if.sv | 11 +
 rtl/mil1553_tx_encoder.sv | 156 +++++++++++++++
 tb/tb_mil1553_tx_encoder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mil1553_tx_encoder_if.sv
// Stream handshake into the MIL-STD-1553 encoder: one 16-bit word plus a
// sync-type flag per transfer.
interface mil1553_tx_encoder_if;
  logic [15:0] tdata;   // word to transmit, MSB first
  logic        tuser;   // 1 = command/status sync, 0 = data sync
  logic        tvalid;
  logic        tready;  // holding register empty

  modport master (output tdata, output tuser, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tvalid, output tready);
endinterface

// File: rtl/mil1553_tx_encoder.sv
// MIL-STD-1553 Manchester transmit encoder. A one-word holding register
// feeds an IDLE/SYNC/DATA/PARITY sequencer; every half-bit lasts HALF clocks
// and each word is 40 half-bits. A word waiting in the holding register at
// the end of PARITY starts its sync on the very next cycle, so consecutive
// words go out with no gap. All line outputs are registered.
module mil1553_tx_encoder #(
  parameter int clock_speed = 8000000,
  parameter int bit_rate    = 1000000
) (
  input  logic                       aclk,
  input  logic                       arst,
  mil1553_tx_encoder_if.slave        s_axis,
  output logic                       tx0_1553,
  output logic                       tx1_1553,
  output logic                       en_tx_1553,
  output logic                       busy
);

  localparam int HALF = clock_speed / (2 * bit_rate);
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;        // clocks within current half-bit
  logic [4:0]    idx_q;        // half-bit index within current state
  logic [15:0]   shift_q;      // word in flight, current bit at [15]
  logic          sync_q;       // sync type of word in flight
  logic          par_q;        // odd parity of word in flight
  logic [15:0]   hold_data_q;
  logic          hold_user_q;
  logic          hold_full_q;
  logic          tready_q;
  logic          tx0_q, tx1_q, en_q, busy_q;

  logic half_end_d, word_end_d, load_d, accept_d;

  assign half_end_d = (cnt_q == CNT_LAST);
  assign word_end_d = (state_q == PARITY) && (idx_q == 5'd1) && half_end_d;
  // A held word starts from IDLE or directly after the previous parity bit.
  assign load_d     = hold_full_q && ((state_q == IDLE) || word_end_d);
  assign accept_d   = s_axis.tvalid && tready_q;

  assign s_axis.tready = tready_q;
  assign tx0_1553      = tx0_q;
  assign tx1_1553      = tx1_q;
  assign en_tx_1553    = en_q;
  assign busy          = busy_q;

  // True and complement line levels for one half-bit.
  function automatic logic [1:0] pair(input logic v);
    return {v, ~v};
  endfunction

  // Sync is three half-bits at one level then three at the other.
  function automatic logic sync_level(input logic user, input logic [4:0] idx);
    return user ? (idx < 5'd3) : (idx >= 5'd3);
  endfunction

  // Holding register: filled on handshake, emptied when the sequencer loads it.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      hold_full_q <= 1'b0;
      tready_q    <= 1'b0;
      hold_data_q <= '0;
      hold_user_q <= 1'b0;
    end else if (load_d) begin
      hold_full_q <= 1'b0;
      tready_q    <= 1'b1;
    end else if (accept_d) begin
      hold_full_q <= 1'b1;
      tready_q    <= 1'b0;
      hold_data_q <= s_axis.tdata;
      hold_user_q <= s_axis.tuser;
    end else begin
      tready_q    <= ~hold_full_q;
    end
  end

  // Sequencer: state, half-bit timing and the registered line levels that
  // belong to the half-bit being entered.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      sync_q   <= 1'b0;
      par_q    <= 1'b0;
      tx0_q    <= 1'b0;
      tx1_q    <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else if (load_d) begin
      state_q          <= SYNC;
      cnt_q            <= '0;
      idx_q            <= '0;
      shift_q          <= hold_data_q;
      sync_q           <= hold_user_q;
      par_q            <= ~^hold_data_q;
      {tx0_q, tx1_q}   <= pair(hold_user_q);
      en_q             <= 1'b1;
      busy_q           <= 1'b1;
    end else if (state_q != IDLE) begin
      if (!half_end_d) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
        case (state_q)
          SYNC: begin
            if (idx_q == 5'd5) begin
              state_q        <= DATA;
              idx_q          <= '0;
              {tx0_q, tx1_q} <= pair(shift_q[15]);
            end else begin
              idx_q          <= idx_q + 5'd1;
              {tx0_q, tx1_q} <= pair(sync_level(sync_q, idx_q + 5'd1));
            end
          end
          DATA: begin
            if (idx_q == 5'd31) begin
              state_q        <= PARITY;
              idx_q          <= '0;
              {tx0_q, tx1_q} <= pair(par_q);
            end else begin
              idx_q <= idx_q + 5'd1;
              if (!idx_q[0]) begin
                {tx0_q, tx1_q} <= pair(~shift_q[15]);
              end else begin
                shift_q        <= {shift_q[14:0], 1'b0};
                {tx0_q, tx1_q} <= pair(shift_q[14]);
              end
            end
          end
          PARITY: begin
            if (idx_q == 5'd0) begin
              idx_q          <= 5'd1;
              {tx0_q, tx1_q} <= pair(~par_q);
            end else begin
              state_q <= IDLE;
              idx_q   <= '0;
              shift_q <= '0;
              tx0_q   <= 1'b0;
              tx1_q   <= 1'b0;
              en_q    <= 1'b0;
              busy_q  <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mil1553_tx_encoder.sv
// Directed bench for the 1553 encoder: one instance at HALF=4, one at HALF=1.
// Each scenario captures the line waveform from the handshake onward and
// compares it against a waveform built from the word and sync type.
module tb_mil1553_tx_encoder;

  logic aclk = 1'b0;
  logic arst;
  always #5 aclk = ~aclk;

  mil1553_tx_encoder_if a_if ();
  mil1553_tx_encoder_if b_if ();

  logic        drv_valid, dut_sel, drv_user;
  logic [15:0] drv_data;
  logic a_tx0, a_tx1, a_en, a_busy, b_tx0, b_tx1, b_en, b_busy;

  assign a_if.tdata  = drv_data;
  assign a_if.tuser  = drv_user;
  assign a_if.tvalid = drv_valid & ~dut_sel;
  assign b_if.tdata  = drv_data;
  assign b_if.tuser  = drv_user;
  assign b_if.tvalid = drv_valid & dut_sel;

  mil1553_tx_encoder #(.clock_speed(8000000), .bit_rate(1000000)) u_a (
    .aclk(aclk), .arst(arst), .s_axis(a_if),
    .tx0_1553(a_tx0), .tx1_1553(a_tx1), .en_tx_1553(a_en), .busy(a_busy));

  mil1553_tx_encoder #(.clock_speed(2000000), .bit_rate(1000000)) u_b (
    .aclk(aclk), .arst(arst), .s_axis(b_if),
    .tx0_1553(b_tx0), .tx1_1553(b_tx1), .en_tx_1553(b_en), .busy(b_busy));

  logic o_tx0, o_tx1, o_en, o_busy, o_rdy;
  assign o_tx0  = dut_sel ? b_tx0  : a_tx0;
  assign o_tx1  = dut_sel ? b_tx1  : a_tx1;
  assign o_en   = dut_sel ? b_en   : a_en;
  assign o_busy = dut_sel ? b_busy : a_busy;
  assign o_rdy  = dut_sel ? b_if.tready : a_if.tready;

  int total = 0;
  int bad   = 0;

  logic [15:0]  st_d [0:3];
  logic         st_u [0:3];
  logic [511:0] cap_tx0, cap_tx1, cap_en, cap_busy, cap_rdy;
  logic [511:0] exp_tx0, exp_tx1, exp_en, exp_rdy;

  // Expected tx0 level for half-bit h of a word.
  function automatic logic hb(input logic [15:0] d, input logic u, input int h);
    logic v;
    if (h < 6) return u ? (h < 3) : (h >= 3);
    if (h < 38) begin
      v = d[15 - (h - 6) / 2];
      return (((h - 6) % 2) == 0) ? v : ~v;
    end
    v = ~^d;
    return (h == 38) ? v : ~v;
  endfunction

  // Presents st_d/st_u words in order, holding tvalid until the list is done.
  task automatic drive(input int nw);
    for (int i = 0; i < nw; i++) begin
      int n = 0;
      drv_data  = st_d[i];
      drv_user  = st_u[i];
      drv_valid = 1'b1;
      while (o_rdy !== 1'b1 && n < 1000) begin
        @(negedge aclk);
        n++;
      end
      total++;
      if (o_rdy !== 1'b1) begin
        bad++;
        $display("FAIL handshake word %0d: tready=%b required 1", i, o_rdy);
      end
      @(negedge aclk);
      $display("word %0d accepted data=%h user=%b", i, st_d[i], st_u[i]);
    end
    drv_valid = 1'b0;
  endtask

  // Samples outputs on n falling edges; sample 0 follows the first handshake.
  task automatic capture(input int n);
    cap_tx0 = '0; cap_tx1 = '0; cap_en = '0; cap_busy = '0; cap_rdy = '0;
    for (int t = 0; t < n; t++) begin
      @(negedge aclk);
      cap_tx0[t]  = o_tx0;
      cap_tx1[t]  = o_tx1;
      cap_en[t]   = o_en;
      cap_busy[t] = o_busy;
      cap_rdy[t]  = o_rdy;
    end
  endtask

  // Sends nw words back to back and checks the whole waveform.
  task automatic run_words(input int nw, input int half, input int n, input string name);
    int w;
    w = 40 * half;
    exp_tx0 = '0; exp_en = '0; exp_rdy = '0;
    for (int j = 0; j < nw; j++)
      for (int h = 0; h < 40; h++)
        for (int k = 0; k < half; k++) begin
          exp_tx0[1 + w*j + h*half + k] = hb(st_d[j], st_u[j], h);
          exp_en[1 + w*j + h*half + k]  = 1'b1;
        end
    exp_tx1 = exp_en & ~exp_tx0;
    for (int t = 1; t < n; t++)
      if (t >= 1 + w*(nw-1) || ((t - 1) % w) == 0) exp_rdy[t] = 1'b1;
    fork
      drive(nw);
      capture(n);
    join
    total++;
    if (cap_tx0 !== exp_tx0) begin
      bad++; $display("FAIL %s tx0: got %h want %h", name, cap_tx0, exp_tx0);
    end
    total++;
    if (cap_tx1 !== exp_tx1) begin
      bad++; $display("FAIL %s tx1: got %h want %h", name, cap_tx1, exp_tx1);
    end
    total++;
    if (cap_en !== exp_en) begin
      bad++; $display("FAIL %s en_tx: got %h want %h", name, cap_en, exp_en);
    end
    total++;
    if (cap_busy !== exp_en) begin
      bad++; $display("FAIL %s busy: got %h want %h", name, cap_busy, exp_en);
    end
    total++;
    if (cap_rdy !== exp_rdy) begin
      bad++; $display("FAIL %s tready: got %h want %h", name, cap_rdy, exp_rdy);
    end
    $display("%s: %0d word(s) checked over %0d cycles", name, nw, n);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge aclk);
    total++;
    if ({a_tx0, a_tx1, a_en, a_busy, a_if.tready} !== 5'b0) begin
      bad++; $display("FAIL reset_a outputs: got %b want 00000", {a_tx0, a_tx1, a_en, a_busy, a_if.tready});
    end
    total++;
    if ({b_tx0, b_tx1, b_en, b_busy, b_if.tready} !== 5'b0) begin
      bad++; $display("FAIL reset_b outputs: got %b want 00000", {b_tx0, b_tx1, b_en, b_busy, b_if.tready});
    end
    arst = 1'b0;
    @(negedge aclk);
    total++;
    if ({a_if.tready, b_if.tready, a_en, b_en} !== 4'b1100) begin
      bad++; $display("FAIL reset_release rdy_a,rdy_b,en_a,en_b: got %b want 1100", {a_if.tready, b_if.tready, a_en, b_en});
    end
    $display("reset checked");
  endtask

  task automatic test_single_words();
    st_d[0] = 16'h0000; st_u[0] = 1'b1; run_words(1, 4, 170, "word_0000_cmd");
    st_d[0] = 16'hFFFF; st_u[0] = 1'b0; run_words(1, 4, 170, "word_ffff_data");
    st_d[0] = 16'h0001; st_u[0] = 1'b0; run_words(1, 4, 170, "word_0001_parity0");
  endtask

  task automatic test_back_to_back();
    st_d[0] = 16'hA5A5; st_u[0] = 1'b1;
    st_d[1] = 16'h1234; st_u[1] = 1'b0;
    run_words(2, 4, 330, "back_to_back");
  endtask

  task automatic test_hold_valid();
    st_d[0] = 16'hC3C3; st_u[0] = 1'b0;
    st_d[1] = 16'h7E01; st_u[1] = 1'b1;
    st_d[2] = 16'h0F80; st_u[2] = 1'b0;
    run_words(3, 4, 490, "hold_valid_3");
  endtask

  task automatic test_reset_mid();
    logic seen_en;
    st_d[0] = 16'h0F0F; st_u[0] = 1'b1;
    fork
      drive(1);
      begin
        repeat (84) @(negedge aclk);  // sample 83: inside data bit 7
        total++;
        if (o_busy !== 1'b1) begin
          bad++; $display("FAIL reset_mid busy_before: got %b want 1", o_busy);
        end
        #2 arst = 1'b1;
        #1;
        total++;
        if ({o_tx0, o_tx1, o_en, o_busy, o_rdy} !== 5'b0) begin
          bad++; $display("FAIL reset_mid immediate: got %b want 00000", {o_tx0, o_tx1, o_en, o_busy, o_rdy});
        end
      end
    join
    repeat (3) @(negedge aclk);
    arst = 1'b0;
    @(negedge aclk);
    total++;
    if ({o_rdy, o_en} !== 2'b10) begin
      bad++; $display("FAIL reset_mid release rdy,en: got %b want 10", {o_rdy, o_en});
    end
    seen_en = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge aclk);
      seen_en = seen_en | o_en | o_busy | o_tx0;
    end
    total++;
    if (seen_en !== 1'b0) begin
      bad++; $display("FAIL reset_mid old_word_resumed: got %b want 0", seen_en);
    end
    st_d[0] = 16'h8000; st_u[0] = 1'b0;
    run_words(1, 4, 170, "after_reset_8000");
  endtask

  task automatic test_half1();
    dut_sel = 1'b1;
    @(negedge aclk);
    st_d[0] = 16'h5555; st_u[0] = 1'b1;
    run_words(1, 1, 50, "half1_5555");
    dut_sel = 1'b0;
    @(negedge aclk);
  endtask

  initial begin
    arst = 1'b1;
    drv_valid = 1'b0;
    drv_data = '0;
    drv_user = 1'b0;
    dut_sel = 1'b0;
    test_reset();
    test_single_words();
    test_back_to_back();
    test_hold_valid();
    test_reset_mid();
    test_half1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

endmodule
